qei_multi: RTL and testbench

//  Multi-channel quadrature encoder interface: NUM_CH independent A/B/Z encoder inputs, x4 decode,

---
 rtl/qei_multi.sv | 154 +++++++++++++++
 tb/tb_qei_multi.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qei_multi.sv
// Multi-channel x4 quadrature encoder interface: synchronised/filtered A/B/Z pins, wrapping
// position counters, index capture, illegal-transition flags and an atomic snapshot.
// Optional feature macro: QEI_INDEX_RESET_EN (index rising edge also zeroes the counter).
module qei_multi #(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned FILT_LEN = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         enc_a,
    input  logic [NUM_CH-1:0]         enc_b,
    input  logic [NUM_CH-1:0]         enc_z,
    input  logic [NUM_CH-1:0]         cnt_clr,
    input  logic [NUM_CH-1:0]         err_clr,
    input  logic [NUM_CH-1:0]         idx_ack,
    input  logic                      snap_req,
    output logic [NUM_CH*CNT_W-1:0]   count,
    output logic [NUM_CH*CNT_W-1:0]   snap_count,
    output logic                      snap_valid,
    output logic [NUM_CH*CNT_W-1:0]   idx_pos,
    output logic [NUM_CH-1:0]         idx_valid,
    output logic [NUM_CH-1:0]         err
);

    localparam int unsigned NPIN = 3 * NUM_CH;
    localparam int unsigned FCW  = 4;

    logic [NPIN-1:0]              pin_raw;
    logic [NPIN-1:0]              sync1_q;
    logic [NPIN-1:0]              sync2_q;
    logic [NPIN-1:0]              filt_q;
    logic [NPIN-1:0]              filt_d;
    logic [NPIN-1:0]              filt_prev_q;
    logic [NPIN-1:0][FCW-1:0]     hold_q;
    logic [NPIN-1:0][FCW-1:0]     hold_d;

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] ipos_q;
    logic [NUM_CH-1:0][CNT_W-1:0] ipos_d;
    logic [NUM_CH-1:0][CNT_W-1:0] snap_q;
    logic [NUM_CH-1:0][CNT_W-1:0] snap_d;
    logic [NUM_CH-1:0]            err_q;
    logic [NUM_CH-1:0]            err_d;
    logic [NUM_CH-1:0]            ival_q;
    logic [NUM_CH-1:0]            ival_d;
    logic                         snap_v_q;
    logic                         snap_v_d;
    logic [NUM_CH-1:0][1:0]       delta_c;
    logic [NUM_CH-1:0]            idx_edge_c;

    // Bit layout: A pins, then B pins, then Z pins
    assign pin_raw = {enc_z, enc_b, enc_a};

    // Quadrature phase numbered in the counting-up direction: 00, 10, 11, 01
    function automatic logic [1:0] quad_phase(input logic a, input logic b);
        return {b, a ^ b};
    endfunction

    // Filter: accept a differing synchronised value once it has held past FILT_LEN counts
    always_comb begin
        filt_d = filt_q;
        hold_d = '0;
        for (int p = 0; p < NPIN; p++) begin
            if (sync2_q[p] != filt_q[p]) begin
                if (hold_q[p] == FCW'(FILT_LEN)) begin
                    filt_d[p] = sync2_q[p];
                end else begin
                    hold_d[p] = hold_q[p] + FCW'(1);
                end
            end
        end
    end

    // Per-channel decode, counter, index capture and error tracking
    always_comb begin
        delta_c    = '0;
        idx_edge_c = '0;
        cnt_d      = cnt_q;
        ipos_d     = ipos_q;
        ival_d     = ival_q;
        err_d      = err_q;
        snap_d     = snap_req ? cnt_q : snap_q;
        snap_v_d   = snap_req;
        for (int i = 0; i < NUM_CH; i++) begin
            delta_c[i]    = quad_phase(filt_q[i], filt_q[NUM_CH+i])
                          - quad_phase(filt_prev_q[i], filt_prev_q[NUM_CH+i]);
            idx_edge_c[i] = filt_q[2*NUM_CH+i] & ~filt_prev_q[2*NUM_CH+i];

            if (cnt_clr[i]) begin
                cnt_d[i] = '0;
`ifdef QEI_INDEX_RESET_EN
            end else if (idx_edge_c[i]) begin
                cnt_d[i] = '0;
`endif
            end else if (delta_c[i] == 2'd1) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (delta_c[i] == 2'd3) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end

            if (delta_c[i] == 2'd2) begin
                err_d[i] = 1'b1;
            end else if (err_clr[i]) begin
                err_d[i] = 1'b0;
            end

            // Capture uses the pre-update counter value
            if (idx_edge_c[i]) begin
                ipos_d[i] = cnt_q[i];
                ival_d[i] = 1'b1;
            end else if (idx_ack[i]) begin
                ival_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            ipos_q      <= '0;
            ival_q      <= '0;
            err_q       <= '0;
            snap_q      <= '0;
            snap_v_q    <= 1'b0;
        end else begin
            sync1_q     <= pin_raw;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            ipos_q      <= ipos_d;
            ival_q      <= ival_d;
            err_q       <= err_d;
            snap_q      <= snap_d;
            snap_v_q    <= snap_v_d;
        end
    end

    assign count      = cnt_q;
    assign snap_count = snap_q;
    assign snap_valid = snap_v_q;
    assign idx_pos    = ipos_q;
    assign idx_valid  = ival_q;
    assign err        = err_q;

endmodule

// File: tb/tb_qei_multi.sv
// Self-checking bench for qei_multi: directed scenarios plus randomized pin/control traffic
// compared every cycle against a delay-line reference model.
module tb_qei_multi;

    localparam int NUM_CH   = 3;
    localparam int CNT_W    = 8;
    localparam int FILT_LEN = 4;
    localparam int NPIN     = 3 * NUM_CH;
    localparam int L        = FILT_LEN + 3;
    localparam int GAP      = FILT_LEN + 3;
`ifdef QEI_INDEX_RESET_EN
    localparam logic [CNT_W-1:0] CH1_AFTER = 8'd1;
    localparam logic [CNT_W-1:0] CH1_IDX   = 8'd0;
`else
    localparam logic [CNT_W-1:0] CH1_AFTER = 8'd101;
    localparam logic [CNT_W-1:0] CH1_IDX   = 8'd100;
`endif

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_CH-1:0]         enc_a, enc_b, enc_z;
    logic [NUM_CH-1:0]         cnt_clr, err_clr, idx_ack;
    logic                      snap_req;
    logic [NUM_CH*CNT_W-1:0]   count, snap_count, idx_pos;
    logic                      snap_valid;
    logic [NUM_CH-1:0]         idx_valid, err;

    logic [NPIN-1:0]           st_pin, gl_pin;
    logic [NPIN-1:0]           hist [64];
    logic [CNT_W-1:0]          m_cnt [NUM_CH];
    logic [CNT_W-1:0]          m_ipos [NUM_CH];
    logic [CNT_W-1:0]          m_snap [NUM_CH];
    logic [NUM_CH-1:0]         m_err, m_ival;
    logic                      m_snapv;
    int                        last_e [NPIN];
    int                        gl_left [NPIN];
    int                        cyc, rst_left, e0;
    int                        n_tests = 0;
    int                        n_fail  = 0;

    always #10 clk = ~clk;

    assign {enc_z, enc_b, enc_a} = st_pin ^ gl_pin;

    qei_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) dut (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
        .cnt_clr(cnt_clr), .err_clr(err_clr), .idx_ack(idx_ack), .snap_req(snap_req),
        .count(count), .snap_count(snap_count), .snap_valid(snap_valid),
        .idx_pos(idx_pos), .idx_valid(idx_valid), .err(err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int phase(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [5:0] hidx(input int c);
        return 6'(c);
    endfunction

    // One clock: update the reference from the inputs sampled at this edge, then compare
    task automatic tick();
        logic [NPIN-1:0]          cur, prv;
        logic [CNT_W-1:0]         old [NUM_CH];
        logic [NUM_CH*CNT_W-1:0]  e_cnt, e_ipos, e_snap;
        int                       d;
        logic                     zr;
        @(posedge clk);
        cyc++;
        if (reset) begin
            for (int k = 0; k < 64; k++) hist[k] = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_cnt[ch] = '0; m_ipos[ch] = '0; m_snap[ch] = '0;
            end
            m_err = '0; m_ival = '0; m_snapv = 1'b0;
            for (int p = 0; p < NPIN; p++) last_e[p] = cyc + 1;
        end else begin
            hist[hidx(cyc)] = st_pin;
            cur = hist[hidx(cyc - L)];
            prv = hist[hidx(cyc - L - 1)];
            m_snapv = snap_req;
            for (int ch = 0; ch < NUM_CH; ch++) old[ch] = m_cnt[ch];
            for (int ch = 0; ch < NUM_CH; ch++) begin
                d  = (phase(cur[ch], cur[NUM_CH+ch]) - phase(prv[ch], prv[NUM_CH+ch]) + 4) % 4;
                zr = cur[2*NUM_CH+ch] && !prv[2*NUM_CH+ch];
                if (d == 1) m_cnt[ch] = old[ch] + CNT_W'(1);
                else if (d == 3) m_cnt[ch] = old[ch] - CNT_W'(1);
`ifdef QEI_INDEX_RESET_EN
                if (zr) m_cnt[ch] = '0;
`endif
                if (cnt_clr[ch]) m_cnt[ch] = '0;
                if (d == 2) m_err[ch] = 1'b1;
                else if (err_clr[ch]) m_err[ch] = 1'b0;
                if (zr) begin
                    m_ipos[ch] = old[ch];
                    m_ival[ch] = 1'b1;
                end else if (idx_ack[ch]) begin
                    m_ival[ch] = 1'b0;
                end
                if (snap_req) m_snap[ch] = old[ch];
            end
        end
        #1;
        cnt_clr = '0; err_clr = '0; idx_ack = '0; snap_req = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            e_cnt[ch*CNT_W +: CNT_W]  = m_cnt[ch];
            e_ipos[ch*CNT_W +: CNT_W] = m_ipos[ch];
            e_snap[ch*CNT_W +: CNT_W] = m_snap[ch];
        end
        check("count", 64'(count), 64'(e_cnt));
        check("err", 64'(err), 64'(m_err));
        check("idx_valid", 64'(idx_valid), 64'(m_ival));
        check("idx_pos", 64'(idx_pos), 64'(e_ipos));
        check("snap_valid", 64'(snap_valid), 64'(m_snapv));
        check("snap_count", 64'(snap_count), 64'(e_snap));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Random stimulus for the next edge, keeping real pin changes filter-legal
    task automatic rand_cycle();
        int e;
        e = cyc + 1;
        if (rst_left == 0 && $urandom_range(0, 599) == 0) rst_left = $urandom_range(1, 2);
        reset = (rst_left > 0);
        if (rst_left > 0) begin
            rst_left--;
            gl_pin = '0;
            for (int p = 0; p < NPIN; p++) gl_left[p] = 0;
        end
        for (int p = 0; p < NPIN; p++) begin
            if (gl_left[p] > 0) begin
                gl_left[p]--;
                if (gl_left[p] == 0) begin
                    gl_pin[p] = 1'b0;
                    last_e[p] = e;
                end
            end else if (e - last_e[p] >= GAP) begin
                int r;
                r = int'($urandom_range(0, 29));
                if (r < 6) begin
                    st_pin[p] = ~st_pin[p];
                    last_e[p] = e;
                end else if (r == 6 && !reset) begin
                    gl_pin[p]  = 1'b1;
                    gl_left[p] = int'($urandom_range(1, FILT_LEN - 1));
                end
            end
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cnt_clr[ch] = ($urandom_range(0, 39) == 0);
            err_clr[ch] = ($urandom_range(0, 19) == 0);
            idx_ack[ch] = ($urandom_range(0, 19) == 0);
        end
        snap_req = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        reset = 1'b1; st_pin = '0; gl_pin = '0;
        cnt_clr = '0; err_clr = '0; idx_ack = '0; snap_req = 1'b0;
        cyc = 100; rst_left = 0; e0 = 0;
        for (int k = 0; k < 64; k++) hist[k] = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_cnt[ch] = '0; m_ipos[ch] = '0; m_snap[ch] = '0;
        end
        m_err = '0; m_ival = '0; m_snapv = 1'b0;
        for (int p = 0; p < NPIN; p++) begin
            last_e[p] = 0; gl_left[p] = 0;
        end

        ticks(3);
        check("rst_count", 64'(count), 64'(0));
        check("rst_snap", 64'(snap_count), 64'(0));
        check("rst_flags", 64'({snap_valid, idx_valid, err}), 64'(0));
        reset = 1'b0;

        // 8 forward steps on ch0, 4-cycle spacing, exact first-update latency
        for (int k = 0; k < 32 + L + 2; k++) begin
            if (k % 4 == 0 && k < 32) begin
                case ((k / 4) % 4)
                    0:       st_pin[0] = 1'b1;
                    1:       st_pin[NUM_CH] = 1'b1;
                    2:       st_pin[0] = 1'b0;
                    default: st_pin[NUM_CH] = 1'b0;
                endcase
            end
            tick();
            if (k == 0) e0 = cyc;
            if (cyc == e0 + L - 1) check("t1_lat_pre", 64'(count[CNT_W-1:0]), 64'(0));
            if (cyc == e0 + L)     check("t1_lat_post", 64'(count[CNT_W-1:0]), 64'(1));
        end
        check("t1_count", 64'(count), 64'(24'h000008));

        // ch1 wrap below zero and back
        st_pin[NUM_CH+1] = 1'b1;
        ticks(L + 2);
        check("t2_wrap_dn", 64'(count[2*CNT_W-1:CNT_W]), 64'(8'hFF));
        st_pin[NUM_CH+1] = 1'b0;
        ticks(L + 2);
        check("t2_wrap_up", 64'(count[2*CNT_W-1:CNT_W]), 64'(0));

        // Short pulses on A ch2 must be rejected
        gl_pin[2] = 1'b1;
        tick();
        gl_pin[2] = 1'b0;
        ticks(GAP + L);
        gl_pin[2] = 1'b1;
        ticks(FILT_LEN - 1);
        gl_pin[2] = 1'b0;
        ticks(GAP + L);
        check("t3_count", 64'(count[3*CNT_W-1:2*CNT_W]), 64'(0));
        check("t3_err", 64'(err[2]), 64'(0));

        // Simultaneous A/B change on ch0
        st_pin[0] = 1'b1;
        st_pin[NUM_CH] = 1'b1;
        ticks(L + 4);
        check("t4_err", 64'(err[0]), 64'(1));
        check("t4_held", 64'(count[CNT_W-1:0]), 64'(8));
        err_clr[0] = 1'b1;
        tick();
        check("t4_errclr", 64'(err[0]), 64'(0));

        // ch1 up to 100, then index
        for (int s = 0; s < 100; s++) begin
            case (s % 4)
                0:       st_pin[1] = 1'b1;
                1:       st_pin[NUM_CH+1] = 1'b1;
                2:       st_pin[1] = 1'b0;
                default: st_pin[NUM_CH+1] = 1'b0;
            endcase
            ticks(4);
        end
        ticks(L + 2);
        check("t5_cnt100", 64'(count[2*CNT_W-1:CNT_W]), 64'(100));
        st_pin[2*NUM_CH+1] = 1'b1;
        ticks(L);
        check("t5_ival_pre", 64'(idx_valid[1]), 64'(0));
        tick();
        check("t5_ival", 64'(idx_valid[1]), 64'(1));
        check("t5_ipos", 64'(idx_pos[2*CNT_W-1:CNT_W]), 64'(100));
        check("t5_cnt_idx", 64'(count[2*CNT_W-1:CNT_W]), 64'(CH1_IDX));
        st_pin[1] = 1'b1;
        ticks(L + 2);
        check("t5_cnt_after", 64'(count[2*CNT_W-1:CNT_W]), 64'(CH1_AFTER));
        idx_ack[1] = 1'b1;
        tick();
        check("t5_ack", 64'(idx_valid[1]), 64'(0));

        // Snapshot taken on the edge where ch2 steps: must hold pre-step value
        st_pin[2] = 1'b1;
        ticks(L);
        snap_req = 1'b1;
        tick();
        check("t6_snapv", 64'(snap_valid), 64'(1));
        check("t6_snap", 64'(snap_count), 64'({8'h00, CH1_AFTER, 8'h08}));
        check("t6_live", 64'(count[3*CNT_W-1:2*CNT_W]), 64'(1));
        tick();
        check("t6_snapv_drop", 64'(snap_valid), 64'(0));
        snap_req = 1'b1;
        tick();
        check("t6_b2b_0", 64'(snap_valid), 64'(1));
        snap_req = 1'b1;
        tick();
        check("t6_b2b_1", 64'(snap_valid), 64'(1));

        // cnt_clr coinciding with a step on ch0
        st_pin[NUM_CH] = 1'b0;
        ticks(L);
        cnt_clr[0] = 1'b1;
        tick();
        check("t6_clr_step", 64'(count[CNT_W-1:0]), 64'(0));

        // Randomized traffic on all channels
        for (int p = 0; p < NPIN; p++) last_e[p] = cyc;
        for (int n = 0; n < 2500; n++) begin
            rand_cycle();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
